traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
- Synthesizable traffic-light controller. Replaces the behavioural light sequencer with clocked RTL.
- Consumes a one-cycle `tick` strobe from the upstream prescaler. Drives the red/amber/green lamps plus a pedestrian walk lamp.
- Sequence is RED -> GREEN -> AMBER -> RED. Each phase lasts a parameterised number of ticks.
- Adds pedestrian early-green-termination and a maintenance amber-flash mode.

Parameters:
- RED_TICS, 350, RED phase duration in ticks (>=1)
- GREEN_TICS, 200, maximum GREEN phase duration in ticks (>=1)
- AMBER_TICS, 30, AMBER phase duration in ticks (>=1)
- MIN_GREEN_TICS, 50, minimum GREEN ticks before a pedestrian request may end GREEN (1..GREEN_TICS)
- CNT_W, 16, phase tick counter width; must hold max(RED_TICS, GREEN_TICS, AMBER_TICS)-1

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- tick  input  1  one-clk strobe from prescaler; all phase timing counts these
- ped_req  input  1  pedestrian button pulse or level, sampled every clk
- flash_en  input  1  maintenance mode request; level
- red  output  1  red lamp
- amber  output  1  amber lamp
- green  output  1  green lamp
- walk  output  1  pedestrian walk lamp
- ped_pending  output  1  latched pedestrian request awaiting service
- phase  output  2  current state: 0 RED, 1 GREEN, 2 AMBER, 3 FLASH

Behaviour:
- Reset (async, active-high): phase=RED, cnt=0, ped_pending=0, flash toggle=0. Outputs: red=1, amber=0, green=0, walk=1.
- Lamp outputs are decoded from registered state only; no combinational path from inputs to lamps.
  - RED: red=1, walk=1.
  - GREEN: green=1.
  - AMBER: amber=1.
  - FLASH: red=green=walk=0, amber=flash toggle.
- Outside FLASH exactly one of red/amber/green is 1 at all times.
- Phase timing (RED, GREEN, AMBER):
  - cnt clears to 0 on phase entry.
  - On each clk with tick=1: if cnt==DUR-1, transition to the next phase and clear cnt; else cnt+1.
  - With tick=0, cnt holds.
  - A phase therefore spans exactly DUR ticks.
  - Lamps change on the clk edge that samples the final tick.
- Transitions: RED -> GREEN after RED_TICS; GREEN -> AMBER after GREEN_TICS; AMBER -> RED after AMBER_TICS.
- Pedestrian latch:
  - ped_pending sets on any clk with ped_req=1 while phase is GREEN or AMBER.
  - ped_req is ignored in RED (walk is already on) and in FLASH.
  - ped_pending clears on the edge that enters RED. If set and clear coincide, clear wins.
- Early termination: in GREEN, on a tick with ped_pending=1 and cnt>=MIN_GREEN_TICS-1, go to AMBER and clear cnt.
  - If ped_req and the qualifying tick arrive on the same clk, no early exit that cycle; ped_pending becomes 1 and acts from the next tick.
- Flash mode:
  - flash_en=1 sampled at any clk forces phase=FLASH on that edge, from any state. Effects: cnt=0, flash toggle=1 (amber lit on the first FLASH cycle), ped_pending=0.
  - In FLASH, flash toggle inverts on each tick.
  - flash_en=0 while in FLASH: next edge goes to RED with cnt=0 and amber=0. This is always a full RED phase.
  - flash_en has priority over tick and over phase expiry on the same clk.
- Reset mid-phase: immediate return to reset values regardless of cnt/phase. No lamp other than red may be on after rst rises.
- cnt never exceeds DUR-1 of the current phase; no wrap-around is possible.

Test Plan:
(Bench parameters: RED_TICS=4, GREEN_TICS=6, AMBER_TICS=2, MIN_GREEN_TICS=2; tick every 3rd clk.)
- Reset then free-run, no ped_req -> phase sequence 0 for 4 ticks, 1 for 6, 2 for 2, back to 0. Check onehot lamps and walk=1 only in RED.
- ped_req pulse after 1st GREEN tick -> ped_pending=1. GREEN ends on 2nd tick. AMBER lasts 2 ticks. ped_pending=0 on entering RED.
- ped_req during RED -> ped_pending stays 0. Green lasts the full 6 ticks.
- flash_en=1 mid-GREEN -> next edge phase=3, amber=1, green=0, ped_pending cleared. Amber toggles per tick. flash_en=0 -> phase=0, red=1, and RED lasts 4 ticks.
- ped_req and the qualifying 2nd GREEN tick on the same clk -> no exit that clk. Exit to AMBER on the 3rd tick.
- rst asserted asynchronously mid-AMBER, between clk edges -> red=1, amber=0, phase=0 immediately. After release, RED lasts 4 ticks.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Traffic-light sequencer RED -> GREEN -> AMBER -> RED timed in prescaler ticks,
// with pedestrian early-green termination and a maintenance amber-flash mode.
module traffic_light_ctrl #(
    parameter int RED_TICS       = 350,
    parameter int GREEN_TICS     = 200,
    parameter int AMBER_TICS     = 30,
    parameter int MIN_GREEN_TICS = 50,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic       red,
    output logic       amber,
    output logic       green,
    output logic       walk,
    output logic       ped_pending,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        PH_RED   = 2'd0,
        PH_GREEN = 2'd1,
        PH_AMBER = 2'd2,
        PH_FLASH = 2'd3
    } phase_e;

    localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_TICS - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_TICS - 1);
    localparam logic [CNT_W-1:0] AMBER_LAST = CNT_W'(AMBER_TICS - 1);
    localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_GREEN_TICS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_q, ped_d;
    logic             tog_q, tog_d;
    logic             red_q, amber_q, green_q, walk_q;
    logic             red_d, amber_d, green_d, walk_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        ped_d   = ped_q;
        tog_d   = tog_q;

        if (flash_en) begin
            // Entering FLASH lights amber at once; staying in FLASH blinks per tick.
            phase_d = PH_FLASH;
            cnt_d   = '0;
            ped_d   = 1'b0;
            tog_d   = (phase_q == PH_FLASH) ? (tog_q ^ tick) : 1'b1;
        end else begin
            case (phase_q)
                PH_RED: begin
                    if (tick) begin
                        if (cnt_q == RED_LAST) begin
                            phase_d = PH_GREEN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                PH_GREEN: begin
                    if (ped_req) ped_d = 1'b1;
                    // Early exit looks at the latched request only, never this cycle's ped_req.
                    if (tick) begin
                        if (cnt_q == GREEN_LAST || (ped_q && cnt_q >= MIN_LAST)) begin
                            phase_d = PH_AMBER;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                PH_AMBER: begin
                    if (ped_req) ped_d = 1'b1;
                    if (tick) begin
                        if (cnt_q == AMBER_LAST) begin
                            phase_d = PH_RED;
                            cnt_d   = '0;
                            ped_d   = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    phase_d = PH_RED;
                    cnt_d   = '0;
                    ped_d   = 1'b0;
                    tog_d   = 1'b0;
                end
            endcase
        end

        red_d   = (phase_d == PH_RED);
        green_d = (phase_d == PH_GREEN);
        walk_d  = (phase_d == PH_RED);
        amber_d = (phase_d == PH_AMBER) || (phase_d == PH_FLASH && tog_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_RED;
            cnt_q   <= '0;
            ped_q   <= 1'b0;
            tog_q   <= 1'b0;
            red_q   <= 1'b1;
            amber_q <= 1'b0;
            green_q <= 1'b0;
            walk_q  <= 1'b1;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            ped_q   <= ped_d;
            tog_q   <= tog_d;
            red_q   <= red_d;
            amber_q <= amber_d;
            green_q <= green_d;
            walk_q  <= walk_d;
        end
    end

    assign red         = red_q;
    assign amber       = amber_q;
    assign green       = green_q;
    assign walk        = walk_q;
    assign ped_pending = ped_q;
    assign phase       = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: hand-computed vector table, async-reset sequence,
// and random stimulus against a tick-counting reference model.
module tb_traffic_light_ctrl;

    localparam int R_T = 4;
    localparam int G_T = 6;
    localparam int A_T = 2;
    localparam int MIN_G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash_en = 1'b0;
    logic       red, amber, green, walk, ped_pending;
    logic [1:0] phase;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase number, ticks consumed in this phase, latch, blink state.
    int m_ph;
    int m_done;
    bit m_pend;
    bit m_tog;
    int dur[3] = '{R_T, G_T, A_T};

    typedef struct {
        int idle;
        bit t;
        bit p;
        bit f;
        int ph;
        bit pend;
        bit fa;
    } vec_t;
    vec_t vecs[$];

    traffic_light_ctrl #(
        .RED_TICS(R_T), .GREEN_TICS(G_T), .AMBER_TICS(A_T),
        .MIN_GREEN_TICS(MIN_G), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .flash_en(flash_en),
        .red(red), .amber(amber), .green(green), .walk(walk),
        .ped_pending(ped_pending), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lamps_of(input int ph, input bit fa);
        bit r, a, g, w;
        r = (ph == 0);
        g = (ph == 1);
        w = (ph == 0);
        a = (ph == 2) || (ph == 3 && fa);
        return {28'd0, r, a, g, w};
    endfunction

    function automatic void model_reset();
        m_ph = 0; m_done = 0; m_pend = 0; m_tog = 0;
    endfunction

    function automatic void model_step(input bit t, input bit p, input bit f);
        bit new_pend;
        bit leave;
        if (f) begin
            m_tog  = (m_ph == 3) ? (m_tog ^ t) : 1'b1;
            m_ph   = 3;
            m_done = 0;
            m_pend = 0;
            return;
        end
        if (m_ph == 3) begin
            m_ph = 0; m_done = 0; m_tog = 0; m_pend = 0;
            return;
        end
        new_pend = m_pend | (p && m_ph != 0);
        if (t) begin
            m_done++;
            leave = (m_done == dur[m_ph]) || (m_ph == 1 && m_pend && m_done >= MIN_G);
            if (leave) begin
                m_ph   = (m_ph + 1) % 3;
                m_done = 0;
                if (m_ph == 0) new_pend = 0;
            end
        end
        m_pend = new_pend;
    endfunction

    // One clock: drive at negedge, model advances at posedge, compare at next negedge.
    task automatic cyc(input bit t, input bit p, input bit f);
        tick = t; ped_req = p; flash_en = f;
        @(posedge clk);
        model_step(t, p, f);
        @(negedge clk);
        chk("model_phase", int'(phase), m_ph);
        chk("model_lamps", int'({red, amber, green, walk}), lamps_of(m_ph, m_tog));
        chk("model_pend", int'(ped_pending), int'(m_pend));
    endtask

    function automatic void add(input int idle, input bit t, input bit p, input bit f,
                                input int ph, input bit pend, input bit fa);
        vec_t v;
        v.idle = idle; v.t = t; v.p = p; v.f = f; v.ph = ph; v.pend = pend; v.fa = fa;
        vecs.push_back(v);
    endfunction

    function automatic void add_ticks(input int n, input int ph, input bit pend);
        for (int i = 0; i < n; i++) add(2, 1, 0, 0, ph, pend, 0);
    endfunction

    initial begin
        // Free run: 4 RED ticks, 6 GREEN, 2 AMBER, back to RED.
        add_ticks(3, 0, 0); add_ticks(1, 1, 0);
        add_ticks(5, 1, 0); add_ticks(1, 2, 0);
        add_ticks(1, 2, 0); add_ticks(1, 0, 0);
        // Pedestrian pulse after first GREEN tick ends GREEN on the second tick.
        add_ticks(3, 0, 0); add_ticks(1, 1, 0);
        add_ticks(1, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add_ticks(1, 2, 1); add_ticks(1, 2, 1); add_ticks(1, 0, 0);
        // Pedestrian request during RED is ignored; GREEN runs full length.
        add(0, 0, 1, 0, 0, 0, 0);
        add_ticks(3, 0, 0); add_ticks(1, 1, 0);
        add_ticks(5, 1, 0); add_ticks(1, 2, 0);
        add_ticks(1, 2, 0); add_ticks(1, 0, 0);
        // Request coinciding with the qualifying second tick acts one tick later.
        add_ticks(3, 0, 0); add_ticks(1, 1, 0);
        add_ticks(1, 1, 0);
        add(2, 1, 1, 0, 1, 1, 0);
        add_ticks(1, 2, 1); add_ticks(1, 2, 1); add_ticks(1, 0, 0);
        // Flash entered mid-GREEN with a pending request, blink, then a full RED.
        add_ticks(3, 0, 0); add_ticks(1, 1, 0);
        add_ticks(1, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 3, 0, 1);
        add(2, 1, 0, 1, 3, 0, 0);
        add(2, 1, 0, 1, 3, 0, 1);
        add(2, 1, 0, 1, 3, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add_ticks(3, 0, 0); add_ticks(1, 1, 0);

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_phase", int'(phase), 0);
        chk("reset_lamps", int'({red, amber, green, walk}), 4'b1001);
        chk("reset_pend", int'(ped_pending), 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            for (int i = 0; i < vecs[k].idle; i++) cyc(0, 0, vecs[k].f);
            cyc(vecs[k].t, vecs[k].p, vecs[k].f);
            chk($sformatf("vec%0d_phase", k), int'(phase), vecs[k].ph);
            chk($sformatf("vec%0d_lamps", k), int'({red, amber, green, walk}),
                lamps_of(vecs[k].ph, vecs[k].fa));
            chk($sformatf("vec%0d_pend", k), int'(ped_pending), int'(vecs[k].pend));
        end

        // Drive GREEN into AMBER, then raise reset between clock edges.
        for (int i = 0; i < G_T; i++) begin
            cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
        end
        chk("pre_rst_phase", int'(phase), 2);
        cyc(0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_phase", int'(phase), 0);
        chk("async_rst_lamps", int'({red, amber, green, walk}), 4'b1001);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= R_T; i++) begin
            cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
            chk($sformatf("post_rst_tick%0d", i), int'(phase), (i == R_T) ? 1 : 0);
        end

        // Random traffic with occasional maintenance windows.
        begin
            bit f = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 79) == 0) f = ~f;
                cyc($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, f);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
